// File: rtl/cmd_frame_parser.sv
// Ethernet command-frame parser: filters on destination MAC, extracts opcode,
// command id, source MAC and little-endian parameter words, and holds each
// good command on a valid/ready output until the consumer takes it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_HDR   | bytes 0..15: dest MAC compare, source MAC, LEN latch
// S_OPC   | bytes 16..19: opcode, first byte lands in [31:24]
// S_ID    | bytes 20..23: command id, little-endian
// S_PARAM | capture K parameter words, little-endian
// S_DRAIN | consume remaining payload/pad up to tlast
// S_HOLD  | command presented on cmd_valid, input stalled
module cmd_frame_parser #(
  parameter logic [47:0] FPGA_MAC_ADDR   = 48'h5a0102030405,
  parameter bit          ALLOW_BCAST     = 1'b0,
  parameter int          NUM_PARAM_WORDS = 7
) (
  input  logic                          gtx_clk_bufg,
  input  logic                          gtx_reset,
  input  logic [7:0]                    rx_axis_tdata,
  input  logic                          rx_axis_tvalid,
  input  logic                          rx_axis_tlast,
  output logic                          rx_axis_tready,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [31:0]                   cmd_opcode,
  output logic [31:0]                   cmd_id,
  output logic [32*NUM_PARAM_WORDS-1:0] cmd_params,
  output logic [5:0]                    cmd_nparams,
  output logic [47:0]                   cmd_src_mac,
  output logic                          frame_error,
  output logic [15:0]                   drop_count
);

  localparam int PW = 32 * NUM_PARAM_WORDS;

  typedef enum logic [2:0] {
    S_HDR, S_OPC, S_ID, S_PARAM, S_DRAIN, S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [10:0]     idx_q, idx_d;
  logic [15:0]     len_q, len_d;
  logic            ucast_mis_q, ucast_mis_d;
  logic            bcast_mis_q, bcast_mis_d;
  logic            dropped_q, dropped_d;
  logic [31:0]     opc_sh_q, opc_sh_d;
  logic [31:0]     id_sh_q, id_sh_d;
  logic [47:0]     src_sh_q, src_sh_d;
  logic [PW-1:0]   par_sh_q, par_sh_d;
  logic [31:0]     opcode_q, opcode_d;
  logic [31:0]     cid_q, cid_d;
  logic [PW-1:0]   params_q, params_d;
  logic [5:0]      nparams_q, nparams_d;
  logic [47:0]     src_q, src_d;
  logic            tready_q, tready_d;
  logic            err_q, err_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic            beat;
  logic [7:0]      exp_byte;
  logic [15:0]     k_raw;
  logic [5:0]      k_val;
  logic [10:0]     param_last;
  logic [10:0]     off;
  logic            hdr_drop;
  logic            short_len;
  logic            to_drain;
  logic            drain_drop;
  logic            cnt_inc;

  assign beat           = rx_axis_tvalid & tready_q;
  assign rx_axis_tready = tready_q;
  assign cmd_valid      = (state_q == S_HOLD);
  assign cmd_opcode     = opcode_q;
  assign cmd_id         = cid_q;
  assign cmd_params     = params_q;
  assign cmd_nparams    = nparams_q;
  assign cmd_src_mac    = src_q;
  assign frame_error    = err_q;
  assign drop_count     = drop_cnt_q;

  // Derived frame quantities: expected MAC byte, word count K, last param byte index.
  always_comb begin
    exp_byte = 8'h00;
    case (idx_q[2:0])
      3'd0:    exp_byte = FPGA_MAC_ADDR[47:40];
      3'd1:    exp_byte = FPGA_MAC_ADDR[39:32];
      3'd2:    exp_byte = FPGA_MAC_ADDR[31:24];
      3'd3:    exp_byte = FPGA_MAC_ADDR[23:16];
      3'd4:    exp_byte = FPGA_MAC_ADDR[15:8];
      default: exp_byte = FPGA_MAC_ADDR[7:0];
    endcase
    // Only meaningful once LEN >= 10 has been confirmed at byte 15.
    k_raw      = (len_q - 16'd10) >> 2;
    k_val      = (k_raw > 16'(NUM_PARAM_WORDS)) ? 6'(NUM_PARAM_WORDS) : k_raw[5:0];
    param_last = 11'd23 + {3'b000, k_val, 2'b00};
    off        = idx_q - 11'd24;
    hdr_drop   = ucast_mis_q & (~ALLOW_BCAST | bcast_mis_q);
    short_len  = ({6'd0, idx_q} < (17'd13 + {1'b0, len_q}));
  end

  // Next-state, shadow capture and output load logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    ucast_mis_d = ucast_mis_q;
    bcast_mis_d = bcast_mis_q;
    dropped_d   = dropped_q;
    opc_sh_d    = opc_sh_q;
    id_sh_d     = id_sh_q;
    src_sh_d    = src_sh_q;
    par_sh_d    = par_sh_q;
    opcode_d    = opcode_q;
    cid_d       = cid_q;
    params_d    = params_q;
    nparams_d   = nparams_q;
    src_d       = src_q;
    err_d       = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    to_drain    = 1'b0;
    drain_drop  = dropped_q;
    cnt_inc     = 1'b0;

    if (state_q == S_HOLD) begin
      if (cmd_ready) state_d = S_HDR;
    end else if (beat) begin
      if (rx_axis_tlast)             idx_d = 11'd0;
      else if (idx_q != 11'h7ff)     idx_d = idx_q + 11'd1;

      case (state_q)
        S_HDR: begin
          if (idx_q == 11'd0) begin
            par_sh_d  = '0;
            dropped_d = 1'b0;
          end
          if (idx_q < 11'd6) begin
            ucast_mis_d = ((idx_q == 11'd0) ? 1'b0 : ucast_mis_q) | (rx_axis_tdata != exp_byte);
            bcast_mis_d = ((idx_q == 11'd0) ? 1'b0 : bcast_mis_q) | (rx_axis_tdata != 8'hff);
          end else if (idx_q < 11'd12) begin
            src_sh_d = {src_sh_q[39:0], rx_axis_tdata};
          end else if (idx_q == 11'd12) begin
            len_d = {rx_axis_tdata, len_q[7:0]};
          end else if (idx_q == 11'd13) begin
            len_d = {len_q[15:8], rx_axis_tdata};
          end else if (idx_q == 11'd15) begin
            if (hdr_drop || (len_q < 16'd10)) begin
              to_drain   = 1'b1;
              drain_drop = 1'b1;
              dropped_d  = 1'b1;
            end else begin
              state_d = S_OPC;
            end
          end
        end
        S_OPC: begin
          opc_sh_d = {opc_sh_q[23:0], rx_axis_tdata};
          if (idx_q == 11'd19) state_d = S_ID;
        end
        S_ID: begin
          case (idx_q[1:0])
            2'd0:    id_sh_d[7:0]   = rx_axis_tdata;
            2'd1:    id_sh_d[15:8]  = rx_axis_tdata;
            2'd2:    id_sh_d[23:16] = rx_axis_tdata;
            default: id_sh_d[31:24] = rx_axis_tdata;
          endcase
          if (idx_q == 11'd23) begin
            if (k_val == 6'd0) to_drain = 1'b1;
            else               state_d  = S_PARAM;
          end
        end
        S_PARAM: begin
          for (int w = 0; w < NUM_PARAM_WORDS; w++) begin
            for (int b = 0; b < 4; b++) begin
              if (off == 11'(4 * w + b)) par_sh_d[32*w + 8*b +: 8] = rx_axis_tdata;
            end
          end
          if (idx_q == param_last) to_drain = 1'b1;
        end
        default: ;
      endcase

      if (to_drain) state_d = S_DRAIN;

      // A tlast on the byte that completes a section counts as the frame end.
      if (rx_axis_tlast) begin
        if ((state_q == S_DRAIN) || to_drain) begin
          if (drain_drop) begin
            state_d = S_HDR;
            cnt_inc = 1'b1;
          end else if (short_len) begin
            state_d = S_HDR;
            err_d   = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            state_d   = S_HOLD;
            opcode_d  = opc_sh_d;
            cid_d     = id_sh_d;
            params_d  = par_sh_d;
            nparams_d = k_val;
            src_d     = src_sh_d;
          end
        end else begin
          state_d = S_HDR;
          err_d   = 1'b1;
          cnt_inc = 1'b1;
        end
      end
    end

    if (cnt_inc && (drop_cnt_q != 16'hffff)) drop_cnt_d = drop_cnt_q + 16'd1;
    tready_d = (state_d != S_HOLD);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge gtx_clk_bufg) begin
    if (gtx_reset) begin
      state_q     <= S_HDR;
      idx_q       <= '0;
      len_q       <= '0;
      ucast_mis_q <= 1'b0;
      bcast_mis_q <= 1'b0;
      dropped_q   <= 1'b0;
      opc_sh_q    <= '0;
      id_sh_q     <= '0;
      src_sh_q    <= '0;
      par_sh_q    <= '0;
      opcode_q    <= '0;
      cid_q       <= '0;
      params_q    <= '0;
      nparams_q   <= '0;
      src_q       <= '0;
      tready_q    <= 1'b0;
      err_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      ucast_mis_q <= ucast_mis_d;
      bcast_mis_q <= bcast_mis_d;
      dropped_q   <= dropped_d;
      opc_sh_q    <= opc_sh_d;
      id_sh_q     <= id_sh_d;
      src_sh_q    <= src_sh_d;
      par_sh_q    <= par_sh_d;
      opcode_q    <= opcode_d;
      cid_q       <= cid_d;
      params_q    <= params_d;
      nparams_q   <= nparams_d;
      src_q       <= src_d;
      tready_q    <= tready_d;
      err_q       <= err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: a default instance (unicast only) and
// a broadcast-enabled instance share clock, reset, data and cmd_ready.
module tb_cmd_frame_parser;

  localparam logic [47:0] MAC = 48'h5a0102030405;
  localparam logic [47:0] SRC = 48'h985aebdb066f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [7:0]   tdata;
  logic         tvalid, tlast, sel_b, cmd_ready;
  logic         tvalid_a, tvalid_b;
  assign tvalid_a = tvalid & ~sel_b;
  assign tvalid_b = tvalid & sel_b;

  logic         rdy_a, cval_a, ferr_a;
  logic [31:0]  opc_a, cid_a;
  logic [223:0] par_a;
  logic [5:0]   np_a;
  logic [47:0]  src_a;
  logic [15:0]  drop_a;

  logic         rdy_b, cval_b, ferr_b;
  logic [31:0]  opc_b, cid_b;
  logic [223:0] par_b;
  logic [5:0]   np_b;
  logic [47:0]  src_b;
  logic [15:0]  drop_b;

  cmd_frame_parser #(.FPGA_MAC_ADDR(MAC), .ALLOW_BCAST(1'b0), .NUM_PARAM_WORDS(7)) dut_a (
    .gtx_clk_bufg(clk), .gtx_reset(rst),
    .rx_axis_tdata(tdata), .rx_axis_tvalid(tvalid_a), .rx_axis_tlast(tlast),
    .rx_axis_tready(rdy_a), .cmd_valid(cval_a), .cmd_ready(cmd_ready),
    .cmd_opcode(opc_a), .cmd_id(cid_a), .cmd_params(par_a), .cmd_nparams(np_a),
    .cmd_src_mac(src_a), .frame_error(ferr_a), .drop_count(drop_a)
  );

  cmd_frame_parser #(.FPGA_MAC_ADDR(MAC), .ALLOW_BCAST(1'b1), .NUM_PARAM_WORDS(7)) dut_b (
    .gtx_clk_bufg(clk), .gtx_reset(rst),
    .rx_axis_tdata(tdata), .rx_axis_tvalid(tvalid_b), .rx_axis_tlast(tlast),
    .rx_axis_tready(rdy_b), .cmd_valid(cval_b), .cmd_ready(cmd_ready),
    .cmd_opcode(opc_b), .cmd_id(cid_b), .cmd_params(par_b), .cmd_nparams(np_b),
    .cmd_src_mac(src_b), .frame_error(ferr_b), .drop_count(drop_b)
  );

  int total = 0;
  int bad   = 0;
  int hs_a = 0, vc_a = 0, err_a = 0, hs_b = 0, err_b = 0;
  logic [31:0] ids_a[$];
  logic [31:0] last_id_b;
  logic [7:0]  fq[$];
  logic [31:0] pw[$];
  int gap_at = -1;

  // Handshake / pulse monitor, sampled mid-cycle so it sees the values the next edge uses.
  always @(negedge clk) begin
    #1;
    if (cval_a) vc_a++;
    if (cval_a && cmd_ready) begin
      hs_a++;
      ids_a.push_back(cid_a);
    end
    if (ferr_a) err_a++;
    if (cval_b && cmd_ready) begin
      hs_b++;
      last_id_b = cid_b;
    end
    if (ferr_b) err_b++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack_pw();
    logic [255:0] v = '0;
    for (int k = pw.size() - 1; k >= 0; k--) v = (v << 32) | 256'(pw[k]);
    return v;
  endfunction

  task automatic mk(input logic [47:0] dst, input logic [15:0] len,
                    input logic [31:0] opc, input logic [31:0] id);
    logic [47:0] t48;
    logic [31:0] t32;
    fq.delete();
    t48 = dst;
    for (int i = 0; i < 6; i++) begin fq.push_back(t48[47:40]); t48 = t48 << 8; end
    t48 = SRC;
    for (int i = 0; i < 6; i++) begin fq.push_back(t48[47:40]); t48 = t48 << 8; end
    fq.push_back(len[15:8]);
    fq.push_back(len[7:0]);
    fq.push_back(8'h00);
    fq.push_back(8'h00);
    t32 = opc;
    for (int i = 0; i < 4; i++) begin fq.push_back(t32[31:24]); t32 = t32 << 8; end
    t32 = id;
    for (int i = 0; i < 4; i++) begin fq.push_back(t32[7:0]); t32 = t32 >> 8; end
    for (int k = 0; k < pw.size(); k++) begin
      t32 = pw[k];
      for (int i = 0; i < 4; i++) begin fq.push_back(t32[7:0]); t32 = t32 >> 8; end
    end
  endtask

  // Present the first n bytes of fq; tlast on byte n-1 when last is set.
  task automatic send(input int n, input bit last);
    int to;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        tvalid = 1'b0;
        repeat (3) @(negedge clk);
      end
      tdata  = fq[i];
      tlast  = last && (i == n - 1);
      tvalid = 1'b1;
      to = 0;
      while (!(sel_b ? rdy_b : rdy_a) && to < 200) begin
        @(negedge clk);
        to++;
      end
      if (to >= 200) begin
        chk("tready_wait", 256'(sel_b ? rdy_b : rdy_a), 256'(1));
        tvalid = 1'b0;
        tlast  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  int hs0, vc0, err0, nq;

  initial begin
    rst = 1'b1; tdata = '0; tvalid = 1'b0; tlast = 1'b0; sel_b = 1'b0; cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tready",  256'(rdy_a),  256'(0));
    chk("rst_valid",   256'(cval_a), 256'(0));
    chk("rst_ferr",    256'(ferr_a), 256'(0));
    chk("rst_drop",    256'(drop_a), 256'(0));
    chk("rst_opcode",  256'(opc_a),  256'(0));
    chk("rst_id",      256'(cid_a),  256'(0));
    chk("rst_params",  256'(par_a),  256'(0));
    chk("rst_nparams", 256'(np_a),   256'(0));
    chk("rst_src",     256'(src_a),  256'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", 256'(rdy_a), 256'(1));

    // Good write frame, seven words, tlast on the last parameter byte.
    pw = '{32'h0, 32'hf6, 32'hc8, 32'h300, 32'h1, 32'h00001000, 32'h0};
    mk(MAC, 16'h0026, 32'h43435757, 32'h00004727);
    hs0 = hs_a; vc0 = vc_a;
    send(fq.size(), 1'b1);
    chk("f1_valid_after_tlast", 256'(cval_a), 256'(1));
    chk("f1_tready_in_hold",    256'(rdy_a),  256'(0));
    @(negedge clk);
    chk("f1_valid_gone",  256'(cval_a), 256'(0));
    chk("f1_tready_back", 256'(rdy_a),  256'(1));
    repeat (2) @(negedge clk);
    chk("f1_handshakes", 256'(hs_a - hs0), 256'(1));
    chk("f1_valid_cyc",  256'(vc_a - vc0), 256'(1));
    chk("f1_opcode",     256'(opc_a), 256'(32'h43435757));
    chk("f1_id",         256'(cid_a), 256'(32'h00004727));
    chk("f1_nparams",    256'(np_a),  256'(7));
    chk("f1_params",     256'(par_a), pack_pw());
    chk("f1_src",        256'(src_a), 256'(SRC));

    // Read frame, one word, Ethernet pad, tvalid gaps in PARAM.
    pw = '{32'hfeedbeef};
    mk(MAC, 16'h000e, 32'h43435252, 32'h00000004);
    for (int i = 0; i < 32; i++) fq.push_back(8'h00);
    gap_at = 25;
    hs0 = hs_a;
    send(fq.size(), 1'b1);
    gap_at = -1;
    repeat (3) @(negedge clk);
    chk("f2_handshakes", 256'(hs_a - hs0), 256'(1));
    chk("f2_opcode",     256'(opc_a), 256'(32'h43435252));
    chk("f2_id",         256'(cid_a), 256'(32'h4));
    chk("f2_nparams",    256'(np_a),  256'(1));
    chk("f2_params",     256'(par_a), 256'(32'hfeedbeef));

    // Destination MAC mismatch: silent drop.
    pw = '{32'h1};
    mk(48'h5a0102030406, 16'h000e, 32'h43435252, 32'h00000005);
    hs0 = hs_a; err0 = err_a;
    send(fq.size(), 1'b1);
    repeat (3) @(negedge clk);
    chk("mis_handshakes", 256'(hs_a - hs0),   256'(0));
    chk("mis_ferr",       256'(err_a - err0), 256'(0));
    chk("mis_drop",       256'(drop_a),       256'(1));
    chk("mis_id_kept",    256'(cid_a),        256'(32'h4));

    // Broadcast: dropped by the unicast-only instance, accepted by the other.
    pw = '{32'hcafe0001};
    mk(48'hffffffffffff, 16'h000e, 32'h46465252, 32'h0000000b);
    hs0 = hs_a;
    send(fq.size(), 1'b1);
    repeat (3) @(negedge clk);
    chk("bc_a_handshakes", 256'(hs_a - hs0), 256'(0));
    chk("bc_a_drop",       256'(drop_a),      256'(2));
    sel_b = 1'b1;
    send(fq.size(), 1'b1);
    sel_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("bc_b_handshakes", 256'(hs_b),      256'(1));
    chk("bc_b_id",         256'(last_id_b), 256'(32'hb));
    chk("bc_b_params",     256'(par_b),     256'(32'hcafe0001));
    chk("bc_b_drop",       256'(drop_b),    256'(0));
    chk("bc_b_ferr",       256'(err_b),     256'(0));

    // Short frame: tlast at byte 20, then a good frame.
    pw = '{32'h0, 32'hf6, 32'hc8, 32'h300, 32'h1, 32'h00001000, 32'h0};
    mk(MAC, 16'h0026, 32'h43435757, 32'h00000077);
    hs0 = hs_a; err0 = err_a;
    send(21, 1'b1);
    repeat (3) @(negedge clk);
    chk("short_ferr",       256'(err_a - err0), 256'(1));
    chk("short_drop",       256'(drop_a),       256'(3));
    chk("short_handshakes", 256'(hs_a - hs0),   256'(0));
    chk("short_id_kept",    256'(cid_a),        256'(32'h4));
    pw = '{32'h00c0ffee};
    mk(MAC, 16'h000e, 32'h43435252, 32'h00000099);
    send(fq.size(), 1'b1);
    repeat (3) @(negedge clk);
    chk("post_short_handshakes", 256'(hs_a - hs0), 256'(1));
    chk("post_short_id",         256'(cid_a),      256'(32'h99));
    chk("post_short_params",     256'(par_a),      256'(32'h00c0ffee));
    chk("post_short_drop",       256'(drop_a),     256'(3));

    // Backpressure: command held while a second frame waits; trailing partial word dropped.
    cmd_ready = 1'b0;
    pw = '{32'h12345678};
    mk(MAC, 16'h0010, 32'h46465757, 32'h00000011);
    fq.push_back(8'haa);
    fq.push_back(8'hbb);
    send(fq.size(), 1'b1);
    @(negedge clk);
    chk("bp_valid",   256'(cval_a), 256'(1));
    chk("bp_nparams", 256'(np_a),   256'(1));
    chk("bp_params",  256'(par_a),  256'(32'h12345678));
    pw = '{32'h0badf00d};
    mk(MAC, 16'h000e, 32'h43435252, 32'h00000022);
    tdata = fq[0];
    tvalid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("bp_tready_low", 256'(rdy_a),  256'(0));
      chk("bp_valid_held", 256'(cval_a), 256'(1));
      chk("bp_id_stable",  256'(cid_a),  256'(32'h11));
    end
    nq = ids_a.size();
    cmd_ready = 1'b1;
    send(fq.size(), 1'b1);
    repeat (3) @(negedge clk);
    chk("bp_two_taken", 256'(ids_a.size() - nq), 256'(2));
    if (ids_a.size() >= nq + 2) begin
      chk("bp_first_id",  256'(ids_a[nq]),     256'(32'h11));
      chk("bp_second_id", 256'(ids_a[nq + 1]), 256'(32'h22));
    end

    // Reset at byte 22 of a frame.
    pw = '{32'h1};
    mk(MAC, 16'h000e, 32'h43435757, 32'h00000033);
    hs0 = hs_a; err0 = err_a;
    send(22, 1'b0);
    tdata = fq[22];
    tvalid = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tvalid = 1'b0;
    chk("mrst_tready",  256'(rdy_a),  256'(0));
    chk("mrst_valid",   256'(cval_a), 256'(0));
    chk("mrst_opcode",  256'(opc_a),  256'(0));
    chk("mrst_id",      256'(cid_a),  256'(0));
    chk("mrst_params",  256'(par_a),  256'(0));
    chk("mrst_nparams", 256'(np_a),   256'(0));
    chk("mrst_src",     256'(src_a),  256'(0));
    chk("mrst_drop",    256'(drop_a), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    pw = '{32'h44444444, 32'h55555555};
    mk(MAC, 16'h0012, 32'h43435757, 32'h00000044);
    send(fq.size(), 1'b1);
    repeat (3) @(negedge clk);
    chk("after_rst_handshakes", 256'(hs_a - hs0),   256'(1));
    chk("after_rst_id",         256'(cid_a),        256'(32'h44));
    chk("after_rst_nparams",    256'(np_a),         256'(2));
    chk("after_rst_params",     256'(par_a),        pack_pw());
    chk("after_rst_drop",       256'(drop_a),       256'(0));
    chk("after_rst_ferr",       256'(err_a - err0), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
